// File: rtl/bp_be_spec_queue.sv
// Speculative FIFO with write, read and commit pointers for replay and clear.
// Optional BP_BE_SPEC_QUEUE_BYPASS_EN gives zero-latency enqueue-to-read on empty.
module bp_be_spec_queue #(
    parameter int width_p = 64,
    parameter int els_p = 8,
    parameter int commit_width_p = 2,
    localparam int ptr_width_lp = $clog2(els_p) + 1,
    localparam int cnt_width_lp = $clog2(els_p + 1),
    localparam int idx_width_lp = $clog2(els_p),
    localparam int ccnt_width_lp = $clog2(commit_width_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [width_p-1:0]       data_i,
    input  logic                     v_i,
    output logic                     ready_o,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    input  logic                     yumi_i,
    input  logic [ccnt_width_lp-1:0] commit_cnt_i,
    input  logic                     roll_i,
    input  logic                     clr_i,
    output logic [cnt_width_lp-1:0]  count_o,
    output logic [cnt_width_lp-1:0]  unread_o,
    output logic [cnt_width_lp-1:0]  issued_o
);

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
    logic [ptr_width_lp-1:0] issued, commit_ext;
    logic [width_p-1:0]      mem [els_p];
    logic                    empty, full, enq, deq, commit_ok, byp;

    assign empty = (rptr_r == wptr_r);
    assign full  = (cptr_r[idx_width_lp-1:0] == wptr_r[idx_width_lp-1:0])
                 && (cptr_r[ptr_width_lp-1] != wptr_r[ptr_width_lp-1]);

    assign ready_o = ~clr_i & ~full;

`ifdef BP_BE_SPEC_QUEUE_BYPASS_EN
    assign byp = empty & v_i & ready_o & ~roll_i;
`else
    assign byp = 1'b0;
`endif

    assign v_o    = (~roll_i & ~empty) | byp;
    assign data_o = ~v_o ? '0
                  : byp  ? data_i
                  : mem[rptr_r[idx_width_lp-1:0]];

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    assign issued     = rptr_r - cptr_r;
    assign commit_ext = ptr_width_lp'(commit_cnt_i);
    assign commit_ok  = (commit_ext <= issued);

    // An illegal commit retires everything issued and no more.
    always_comb begin
        cptr_n = rptr_r;
        rptr_n = rptr_r;
        wptr_n = wptr_r;
        if (commit_ok)
            cptr_n = cptr_r + commit_ext;
        if (roll_i)
            rptr_n = cptr_n;
        else
            rptr_n = rptr_r + ptr_width_lp'(deq);
        if (clr_i)
            wptr_n = rptr_n;
        else
            wptr_n = wptr_r + ptr_width_lp'(enq);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wptr_r[idx_width_lp-1:0]] <= data_i;
    end

    assign count_o  = cnt_width_lp'(wptr_r - cptr_r);
    assign unread_o = cnt_width_lp'(wptr_r - rptr_r);
    assign issued_o = cnt_width_lp'(issued);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i & ~v_o & ~roll_i))
                else $error("yumi_i asserted without v_o");
            assert (commit_ok)
                else $error("commit_cnt_i exceeds issued entries");
            assert (els_p >= 2 && (els_p & (els_p - 1)) == 0)
                else $error("els_p must be a power of two >= 2");
            assert (commit_width_p >= 1 && commit_width_p <= els_p)
                else $error("commit_width_p out of range");
        end
    end
`endif

endmodule

// File: doc/bp_be_spec_queue.md
Name: bp_be_spec_queue

Overview:
- Parametrised speculative FIFO for the BE front end: the successor of the fixed-width issue queue.
- Generic payload width, power-of-two depth, and multi-entry commit per cycle.
- Three pointers (write, read, commit), so entries read but not yet committed can be replayed on roll, and unread entries can be dropped on clear.
- Exports occupancy counts to the scheduler and sits between the FE queue interface and the issue stage.

Parameters:
- width_p, 64, payload width in bits.
- els_p, 8, entry count; power of two, at least 2.
- commit_width_p, 2, maximum entries committed in one cycle; 1 to els_p.
- ptr_width_lp, $clog2(els_p)+1, pointer width including the wrap bit (localparam).
- cnt_width_lp, $clog2(els_p+1), width of the count outputs (localparam).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_i  in  width_p  enqueue payload.
- v_i  in  1  enqueue valid.
- ready_o  out  1  enqueue ready; transfer happens when v_i & ready_o.
- data_o  out  width_p  payload at the read pointer; '0 when v_o=0.
- v_o  out  1  unread entry available.
- yumi_i  in  1  consume the entry at the read pointer; legal only when v_o=1.
- commit_cnt_i  in  $clog2(commit_width_p+1)  number of oldest read entries to retire this cycle.
- roll_i  in  1  rewind the read pointer to the commit pointer (replay).
- clr_i  in  1  drop all unread entries.
- count_o  out  cnt_width_lp  occupied entries, wptr-cptr.
- unread_o  out  cnt_width_lp  unread entries, wptr-rptr.
- issued_o  out  cnt_width_lp  read but uncommitted entries, rptr-cptr.

Behaviour:
- Reset (reset_n_i=0, asynchronous): wptr=rptr=cptr=0, so v_o=0, ready_o=1, all counts 0, data_o='0. Reset applies mid-operation with no drain; storage is not reset.
- Pointer arithmetic is modulo 2*els_p; the low bits index storage.
  - empty: rptr==wptr.
  - full: cptr and wptr low bits equal and wrap bits differ.
- ready_o = ~clr_i & ~full. v_o = ~roll_i & ~empty. Both are combinational from registered pointers and the same-cycle control inputs.
- Enqueue: write mem[wptr] and wptr+=1. Read latency is 1 cycle: an entry enqueued in cycle N is visible on data_o/v_o in cycle N+1.
- Read: on yumi_i & v_o, rptr+=1. data_o is a combinational read of mem[rptr].
- Commit: cptr += commit_cnt_i.
  - commit_cnt_i must not exceed issued_o as registered at the start of the cycle.
  - Violation fires an assertion and cptr is clamped to rptr.
  - Freed slots are enqueueable from the next cycle. There is no same-cycle full bypass.
- Roll: rptr_n = cptr_r + commit_cnt_i. yumi_i is ignored. Enqueue proceeds normally.
- Clear: wptr_n = rptr_n, where rptr_n already includes a same-cycle read or roll. The enqueue is blocked.
- Roll and clear together: rptr_n = wptr_n = cptr_r + commit_cnt_i. All uncommitted entries are discarded; committed ones are already gone.
- Enqueue and read on an empty queue in the same cycle: the read is not permitted, since v_o=0, unless bypass is compiled in.
- Enqueue when full with a commit in the same cycle: still blocked.
- Wrap-around: pointers pass 2*els_p-1 → 0. Full and empty stay correct across at least 3 laps.
- Assertions, outside synthesis:
  - yumi_i & ~v_o.
  - commit overflow.
  - els_p not a power of two.
  - commit_width_p > els_p.

Optional Feature:
- Macro: BP_BE_SPEC_QUEUE_BYPASS_EN.
- When defined, an empty queue with v_i & ready_o & ~roll_i & ~clr_i drives data_o=data_i and v_o=1 in the same cycle.
  - If yumi_i is also asserted, the entry is still written, and wptr and rptr both advance (issued_o+1 next cycle).
  - Enqueue-to-read latency becomes 0.
- When undefined, enqueue-to-read latency is 1 cycle and v_o depends only on registered pointers and roll_i.

Test Plan (els_p=4, width_p=8, commit_width_p=2):
- Reset, then enqueue 0x11,0x22,0x33,0x44 → ready_o=0 after the 4th, count_o=4; a 5th v_i is not accepted.
- From full, read 2 then commit_cnt_i=2 → issued_o 2→0, count_o=2, ready_o=1 the next cycle; enqueue 0x55 lands at slot 0 (wrap).
- Enqueue A,B,C; read A,B; roll_i=1 → v_o=0 that cycle; next cycle data_o=A, unread_o=3, issued_o=0.
- Enqueue A,B,C; read A; clr_i=1 with v_i=1 → input not accepted; next cycle unread_o=0, issued_o=1, count_o=1, v_o=0.
- Roll and clear in the same cycle with commit_cnt_i=1 and issued_o=2 → next cycle count_o=0, v_o=0, ready_o=1.
- Run 12 enqueue/read/commit cycles (3 laps) of random data → FIFO order preserved, no false full/empty; with BYPASS_EN, enqueue 0x77 plus yumi_i on an empty queue → data_o=0x77 the same cycle, issued_o=1 next.
